// File: rtl/fifo_wr_arb_if.sv
// Write-arbiter bundle: requester handshakes, FIFO occupancy and write port.
// slave = arbiter side, master = requesters/FIFO side.
interface fifo_wr_arb_if #(
  parameter int WIDTH  = 8,
  parameter int NB_REQ = 4,
  parameter int ADDR   = 4
);
  logic [NB_REQ-1:0]       req_valid;
  logic [NB_REQ*WIDTH-1:0] req_data;
  logic [NB_REQ-1:0]       req_ready;
  logic [ADDR:0]           occup;
  logic                    wr_en;
  logic [WIDTH-1:0]        wr_data;
  logic [NB_REQ-1:0]       grant;

  modport slave (
    input  req_valid, req_data, occup,
    output req_ready, wr_en, wr_data, grant
  );

  modport master (
    output req_valid, req_data, occup,
    input  req_ready, wr_en, wr_data, grant
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding NB_REQ requesters into one FIFO.
// Ports: clk, rst_n (async low), bus (req_*, occup in; wr_*, grant out).
module fifo_wr_arb #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR      = $clog2(DEPTH),
  parameter int NB_REQ    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_wr_arb_if.slave  bus
);

  localparam int IW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]        state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     g_idx;
  logic [BW-1:0]     burst_cnt;
  logic [NB_REQ-1:0] grant_q;
  logic              wr_en_q;
  logic [WIDTH-1:0]  wr_data_q;

  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic [IW-1:0]     next_ptr;
  logic [ADDR+1:0]   level;
  logic              space;
  logic              g_valid;
  logic              xfer;
  logic              last;
  logic [WIDTH-1:0]  g_data;
  logic [NB_REQ-1:0] pick_hot;

  // Occupancy lags one write; count the in-flight word.
  assign level = {1'b0, bus.occup} + (ADDR+2)'(wr_en_q);
  assign space = level < (ADDR+2)'(DEPTH);

  assign g_valid = bus.req_valid[g_idx];
  assign g_data  = bus.req_data[int'(g_idx)*WIDTH +: WIDTH];
  assign xfer    = (state == GRANT) & g_valid & space;
  assign last    = (burst_cnt == BW'(MAX_BURST - 1));

  assign next_ptr = (g_idx == IW'(NB_REQ - 1)) ? '0 : g_idx + 1'b1;

  // Walk down so the nearest index above rr_ptr is written last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(rr_ptr) + k) % NB_REQ;
      if (bus.req_valid[j]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(j);
      end
    end
  end

  assign pick_hot = {{(NB_REQ-1){1'b0}}, 1'b1} << pick_idx;

  assign bus.req_ready = (state == GRANT && space)
                       ? (grant_q & bus.req_valid) : '0;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.grant     = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      g_idx     <= '0;
      burst_cnt <= '0;
      grant_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= xfer;
      if (xfer) begin
        wr_data_q <= g_data;
        burst_cnt <= burst_cnt + BW'(1);
      end
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= GRANT;
            g_idx     <= pick_idx;
            grant_q   <= pick_hot;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (!g_valid || (xfer && last)) begin
            state   <= IDLE;
            grant_q <= '0;
            rr_ptr  <= next_ptr;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: reset, round-robin, short burst,
// full stall and asynchronous reset mid-burst.
module tb_fifo_wr_arb;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR   = 4;
  localparam int NB_REQ = 4;
  localparam int MB     = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fifo_wr_arb_if #(
    .WIDTH(WIDTH), .NB_REQ(NB_REQ), .ADDR(ADDR)
  ) bus ();

  fifo_wr_arb #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR),
    .NB_REQ(NB_REQ), .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dat(input int i);
    return 8'hA0 + 8'(i * 'h11);
  endfunction

  function automatic logic [3:0] hot(input int i);
    return 4'b0001 << i;
  endfunction

  initial begin
    int seq [5];
    seq = '{0, 1, 2, 3, 0};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus.occup     = '0;
    #1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);

    step();
    rst_n         = 1'b1;
    bus.req_valid = 4'b1111;

    // Round-robin, four words per grant, one bubble between grants.
    for (int s = 0; s < 5; s++) begin
      step();
      chk("rr_grant", 32'(bus.grant), 32'(hot(seq[s])));
      chk("rr_bubble", 32'(bus.wr_en), 32'h0);
      chk("rr_ready", 32'(bus.req_ready), 32'(hot(seq[s])));
      for (int w = 0; w < MB; w++) begin
        step();
        chk("rr_wr_en", 32'(bus.wr_en), 32'h1);
        chk("rr_wr_data", 32'(bus.wr_data), 32'(dat(seq[s])));
        if (w == MB - 1) begin
          chk("rr_release", 32'(bus.grant), 32'h0);
          chk("rr_idle_ready", 32'(bus.req_ready), 32'h0);
        end
      end
    end

    // Short burst: rr_ptr is 1, only req 2 asks for two cycles.
    bus.req_valid = 4'b0100;
    step();
    chk("sb_grant", 32'(bus.grant), 32'h4);
    chk("sb_no_wr", 32'(bus.wr_en), 32'h0);
    step();
    chk("sb_wr1", 32'(bus.wr_en), 32'h1);
    chk("sb_d1", 32'(bus.wr_data), 32'hC2);
    step();
    chk("sb_wr2", 32'(bus.wr_en), 32'h1);
    chk("sb_d2", 32'(bus.wr_data), 32'hC2);
    chk("sb_hold", 32'(bus.grant), 32'h4);
    bus.req_valid = 4'b0000;
    step();
    chk("sb_release", 32'(bus.grant), 32'h0);
    chk("sb_wr_off", 32'(bus.wr_en), 32'h0);
    bus.req_valid = 4'b1111;
    step();
    chk("sb_next3", 32'(bus.grant), 32'h8);
    bus.req_valid = 4'b0000;
    step();
    chk("sb_drop3", 32'(bus.grant), 32'h0);

    // Full stall around occupancy 14/15 with a write in flight.
    bus.req_valid = 4'b0001;
    bus.occup     = 5'd14;
    step();
    chk("fs_grant", 32'(bus.grant), 32'h1);
    chk("fs_ready14", 32'(bus.req_ready), 32'h1);
    step();
    chk("fs_wr1", 32'(bus.wr_en), 32'h1);
    bus.occup = 5'd15;
    #1;
    chk("fs_ready_inflight", 32'(bus.req_ready), 32'h0);
    step();
    chk("fs_stall_wr", 32'(bus.wr_en), 32'h0);
    chk("fs_stall_grant", 32'(bus.grant), 32'h1);
    bus.occup = 5'd16;
    #1;
    chk("fs_ready_full", 32'(bus.req_ready), 32'h0);
    step();
    chk("fs_stall2_wr", 32'(bus.wr_en), 32'h0);
    chk("fs_stall2_grant", 32'(bus.grant), 32'h1);
    bus.occup = 5'd14;
    #1;
    chk("fs_ready_drop", 32'(bus.req_ready), 32'h1);
    step();
    chk("fs_wr2", 32'(bus.wr_en), 32'h1);
    chk("fs_d2", 32'(bus.wr_data), 32'hA0);
    bus.occup = 5'd15;
    #1;
    chk("fs_ready_again", 32'(bus.req_ready), 32'h0);
    step();
    chk("fs_stall3_wr", 32'(bus.wr_en), 32'h0);
    chk("fs_stall3_grant", 32'(bus.grant), 32'h1);
    // Two words left in the burst: stalls must not have counted.
    bus.occup = 5'd0;
    step();
    chk("fs_wr3", 32'(bus.wr_en), 32'h1);
    chk("fs_hold3", 32'(bus.grant), 32'h1);
    step();
    chk("fs_wr4", 32'(bus.wr_en), 32'h1);
    chk("fs_release", 32'(bus.grant), 32'h0);

    // Asynchronous reset mid-burst, rr_ptr is 1 here.
    bus.req_valid = 4'b1111;
    step();
    chk("ar_grant", 32'(bus.grant), 32'h2);
    step();
    chk("ar_wr", 32'(bus.wr_en), 32'h1);
    chk("ar_d", 32'(bus.wr_data), 32'hB1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant0", 32'(bus.grant), 32'h0);
    chk("ar_wr0", 32'(bus.wr_en), 32'h0);
    chk("ar_ready0", 32'(bus.req_ready), 32'h0);
    chk("ar_data0", 32'(bus.wr_data), 32'h0);
    step();
    chk("ar_hold_wr", 32'(bus.wr_en), 32'h0);
    rst_n = 1'b1;
    step();
    chk("ar_first0", 32'(bus.grant), 32'h1);
    chk("ar_no_pulse", 32'(bus.wr_en), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
